// File: rtl/fifo_rd_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : fifo_pkg
//  Purpose   : Shared defaults and the beat-counter width helper for the
//              async-FIFO read-side stream engine.
//  Revision  : 1.0  initial release
// ============================================================================
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_PKT_LEN    = 8;

  // Sized to hold PKT_LEN itself so PKT_LEN=1 still gets a 1-bit counter.
  function automatic int cnt_width(input int pkt_len);
    return $clog2(pkt_len + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_stream_if.sv
`default_nettype none
// ============================================================================
//  Interface : fifo_rd_stream_if
//  Purpose   : FIFO read port plus framed valid/ready output stream.
//  Revision  : 1.0  initial release
// ============================================================================
interface fifo_rd_stream_if import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PKT_LEN    = DEF_PKT_LEN
);

  localparam int CNT_WIDTH = cnt_width(PKT_LEN);

  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic [CNT_WIDTH-1:0]  beat_cnt;

  modport master (
    input  fifo_empty, fifo_rd_data, out_ready,
    output fifo_rd_en, out_valid, out_data, out_last, beat_cnt
  );

  modport slave (
    output fifo_empty, fifo_rd_data, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_last, beat_cnt
  );

endinterface
`default_nettype wire

// File: rtl/fifo_rd_stream_skid_buf2.sv
`default_nettype none
// ============================================================================
//  Module    : skid_buf2
//  Purpose   : Two-entry in-order register buffer; head_o is the oldest word.
//  Revision  : 1.0  initial release
// ============================================================================
module skid_buf2 import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            occ_o
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  pop_ok;

  assign pop_ok = pop_i && (occ_q != 2'd0);
  assign head_o = head_q;
  assign occ_o  = occ_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush_i) begin
      occ_d = 2'd0;
    end else begin
      case ({push_i, pop_ok})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_d = push_data_i;
            occ_d  = 2'd1;
          end else begin
            tail_d = push_data_i;
            occ_d  = 2'd2;
          end
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the head moves to the next stored word.
          if (occ_q == 2'd1) begin
            head_d = push_data_i;
          end else begin
            head_d = tail_q;
            tail_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !flush_i && !pop_ok && (occ_q == 2'd2)));

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module    : fifo_rd_stream
//  Purpose   : Drains the async FIFO read port into a framed valid/ready
//              stream through a 2-entry skid buffer (rd_clk domain only).
//  Revision  : 1.0  initial release
// ============================================================================
module fifo_rd_stream import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PKT_LEN    = DEF_PKT_LEN
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             clr,
  fifo_rd_stream_if.master bus
);

  localparam int                   CNT_WIDTH = cnt_width(PKT_LEN);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(PKT_LEN - 1);

  logic                 inflight_q;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [1:0]           occ;
  logic                 pop_now;
  logic [2:0]           credit;

  assign pop_now       = bus.out_valid && bus.out_ready;
  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_last  = bus.out_valid && (beat_cnt_q == LAST_CNT);
  assign bus.beat_cnt  = beat_cnt_q;

  // Words already committed (buffered + in flight) net of this cycle's pop
  // must leave room for one more, so the capture can never overflow.
  assign credit         = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop_now};
  assign bus.fifo_rd_en = !rd_rst && !bus.fifo_empty && !clr && (credit < 3'd2);

  skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i       (rd_clk),
    .rst_i       (rd_rst),
    .flush_i     (clr),
    .push_i      (inflight_q),
    .push_data_i (bus.fifo_rd_data),
    .pop_i       (pop_now),
    .head_o      (bus.out_data),
    .occ_o       (occ)
  );

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (clr) begin
      beat_cnt_d = '0;
    end else if (pop_now) begin
      beat_cnt_d = (beat_cnt_q == LAST_CNT) ? '0 : beat_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      inflight_q <= bus.fifo_rd_en;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module    : tb_fifo_rd_stream
//  Purpose   : Randomised scoreboard bench for fifo_rd_stream (PKT_LEN 8 and 1).
//  Revision  : 1.0  initial release
// ============================================================================
module tb_fifo_rd_stream;

  localparam int DW  = 4;
  localparam int PKT = 8;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic clr1;

  always #5 clk = ~clk;

  fifo_rd_stream_if #(.DATA_WIDTH(DW), .PKT_LEN(PKT)) bus ();
  fifo_rd_stream_if #(.DATA_WIDTH(DW), .PKT_LEN(1))   bus1 ();

  fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PKT)) dut (
    .rd_clk (clk),
    .rd_rst (rst),
    .clr    (clr),
    .bus    (bus)
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(1)) dut1 (
    .rd_clk (clk),
    .rd_rst (rst),
    .clr    (clr1),
    .bus    (bus1)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: words still in the source FIFO, words popped but not yet
  // delivered, and the position of the next beat within its packet.
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int            beat_idx  = 0;
  int            delivered = 0;
  logic          gap       = 1'b0;
  logic          hold      = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic          obs_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic upd_empty();
    bus.fifo_empty = (src_q.size() == 0) || gap;
  endtask

  task automatic step();
    logic          p;
    logic [DW-1:0] w;
    w = '0;
    @(negedge clk);
    obs_valid = bus.out_valid;
    check("no_pop_when_empty", {31'd0, bus.fifo_rd_en && bus.fifo_empty}, 0);
    check("beat_cnt", {28'd0, bus.beat_cnt}, beat_idx);
    if (hold) begin
      check("hold_valid", {31'd0, bus.out_valid}, 1);
      check("hold_data", {28'd0, bus.out_data}, {28'd0, hold_data});
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", {31'd0, bus.out_valid}, 0);
      end else begin
        check("data", {28'd0, bus.out_data}, {28'd0, exp_q.pop_front()});
        check("last", {31'd0, bus.out_last}, (beat_idx == PKT - 1) ? 1 : 0);
        beat_idx = (beat_idx + 1) % PKT;
        delivered++;
      end
    end
    hold      = bus.out_valid && !bus.out_ready && !clr;
    hold_data = bus.out_data;
    if (clr) begin
      exp_q.delete();
      beat_idx = 0;
    end
    p = bus.fifo_rd_en && !bus.fifo_empty;
    if (p) begin
      w = src_q.pop_front();
      exp_q.push_back(w);
    end
    check("outstanding_le2", {31'd0, exp_q.size() <= 2}, 1);
    @(posedge clk);
    #1;
    bus.fifo_rd_data = p ? w : DW'($urandom);
    upd_empty();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    clr = 1'b0;
    gap = 1'b0;
    upd_empty();
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_done", {31'd0, src_q.size() == 0 && exp_q.size() == 0}, 1);
    check("drain_idle", {31'd0, bus.out_valid}, 0);
  endtask

  initial begin
    int            d0;
    int            lost;
    logic [DW-1:0] s1[$];
    logic [DW-1:0] e1[$];
    logic [DW-1:0] w1;
    logic          p1;
    int            n1;

    rst = 1'b1;
    clr = 1'b0;
    clr1 = 1'b0;
    bus.out_ready    = 1'b0;
    bus.fifo_rd_data = '0;
    bus1.fifo_empty   = 1'b1;
    bus1.out_ready    = 1'b1;
    bus1.fifo_rd_data = '0;
    for (int i = 0; i < 16; i++) src_q.push_back(DW'(i));
    upd_empty();

    // Reset values, with a non-empty FIFO so the pop gate is exercised.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.out_valid}, 0);
    check("rst_data", {28'd0, bus.out_data}, 0);
    check("rst_last", {31'd0, bus.out_last}, 0);
    check("rst_cnt", {28'd0, bus.beat_cnt}, 0);
    check("rst_rd_en", {31'd0, bus.fifo_rd_en}, 0);

    // Steady stream 0..15: valid from cycle 2 for 16 consecutive cycles.
    bus.out_ready = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("steady_valid", {31'd0, obs_valid}, (i >= 2 && i < 18) ? 1 : 0);
    end
    check("steady_count", delivered, 16);
    check("steady_cnt_wrap", {28'd0, bus.beat_cnt}, 0);

    // Backpressure.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) src_q.push_back(DW'($urandom));
    upd_empty();
    d0 = delivered;
    repeat (5) step();
    check("bp_rd_en", {31'd0, bus.fifo_rd_en}, 0);
    check("bp_valid", {31'd0, bus.out_valid}, 1);
    check("bp_held", exp_q.size(), 2);
    drain(60);
    check("bp_count", delivered - d0, 10);

    // Empty gaps with random ready and occasional flushes.
    for (int i = 0; i < 40; i++) src_q.push_back(DW'($urandom));
    for (int c = 0; c < 150; c++) begin
      gap = ((c / 3) % 2) == 1;
      bus.out_ready = 1'($urandom % 2);
      clr = ($urandom % 40) == 0;
      upd_empty();
      step();
    end
    drain(100);

    // Flush with one word buffered and one in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) src_q.push_back(DW'($urandom));
    upd_empty();
    d0 = delivered;
    repeat (2) step();
    check("fl_pre_outstanding", exp_q.size(), 2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("fl_valid", {31'd0, bus.out_valid}, 0);
    check("fl_cnt", {28'd0, bus.beat_cnt}, 0);
    drain(60);
    check("fl_count", delivered - d0, 4);

    // Asynchronous reset between clock edges, mid-stream.
    for (int i = 0; i < 10; i++) src_q.push_back(DW'($urandom));
    bus.out_ready = 1'b1;
    upd_empty();
    d0 = delivered;
    repeat (4) step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, bus.out_valid}, 0);
    check("arst_data", {28'd0, bus.out_data}, 0);
    check("arst_last", {31'd0, bus.out_last}, 0);
    check("arst_cnt", {28'd0, bus.beat_cnt}, 0);
    check("arst_rd_en", {31'd0, bus.fifo_rd_en}, 0);
    lost = exp_q.size();
    exp_q.delete();
    beat_idx = 0;
    hold = 1'b0;
    step();
    rst = 1'b0;
    drain(60);
    check("arst_count", delivered - d0, 10 - lost);

    // PKT_LEN=1 instance: every beat is last, counter stays at 0.
    s1.push_back(4'd9);
    s1.push_back(4'd3);
    s1.push_back(4'd12);
    s1.push_back(4'd5);
    bus1.fifo_empty = 1'b0;
    n1 = 0;
    w1 = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus1.out_valid && bus1.out_ready) begin
        if (e1.size() == 0) begin
          check("p1_spurious", {31'd0, bus1.out_valid}, 0);
        end else begin
          check("p1_data", {28'd0, bus1.out_data}, {28'd0, e1.pop_front()});
          check("p1_last", {31'd0, bus1.out_last}, 1);
          check("p1_cnt", {31'd0, bus1.beat_cnt}, 0);
          n1++;
        end
      end
      p1 = bus1.fifo_rd_en && !bus1.fifo_empty;
      if (p1) begin
        w1 = s1.pop_front();
        e1.push_back(w1);
      end
      @(posedge clk);
      #1;
      bus1.fifo_rd_data = p1 ? w1 : DW'($urandom);
      bus1.fifo_empty   = (s1.size() == 0);
    end
    check("p1_count", n1, 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
